// File: rtl/ssd1331_cmd_sequencer_if.sv
// ssd1331_cmd_sequencer_if: packet bus to the MOSI buffer
// plus the RGB565 pixel stream into the sequencer.
interface ssd1331_cmd_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  logic                 i_FINAL_BYTE;
  logic                 i_PIX_VALID;
  logic [15:0]          i_PIX_DATA;
  logic                 o_PIX_READY;
  logic [WIDTH*N-1:0]   o_DATA;
  logic [N-1:0]         o_DC;
  logic                 o_START;

  modport master (
    input  i_FINAL_BYTE,
    input  i_PIX_VALID,
    input  i_PIX_DATA,
    output o_PIX_READY,
    output o_DATA,
    output o_DC,
    output o_START
  );

  modport slave (
    output i_FINAL_BYTE,
    output i_PIX_VALID,
    output i_PIX_DATA,
    input  o_PIX_READY,
    input  o_DATA,
    input  o_DC,
    input  o_START
  );
endinterface

// File: rtl/ssd1331_cmd_sequencer.sv
// ssd1331_cmd_sequencer: SSD1331 power-up, init packets,
// then RGB565 pixels packed four per 8-byte data packet.
module ssd1331_cmd_sequencer #(
  parameter int WIDTH    = 8,
  parameter int N        = 8,
  parameter int PWR_WAIT = 128,
  parameter int RES_LOW  = 32,
  parameter int RES_WAIT = 32,
  parameter int VCC_WAIT = 625000
) (
  input  logic                   i_SCK,
  input  logic                   i_RST,
  ssd1331_cmd_sequencer_if.master bus,
  output logic                   o_RES,
  output logic                   o_VCCEN,
  output logic                   o_PMODEN,
  output logic                   o_INIT_DONE
);

  localparam logic [3:0] S_PWR      = 4'd0;
  localparam logic [3:0] S_RES_LO   = 4'd1;
  localparam logic [3:0] S_RES_HI   = 4'd2;
  localparam logic [3:0] S_CMD      = 4'd3;
  localparam logic [3:0] S_CMD_WAIT = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_VCC      = 4'd6;
  localparam logic [3:0] S_READY    = 4'd7;
  localparam logic [3:0] S_PIX      = 4'd8;
  localparam logic [3:0] S_PIX_WAIT = 4'd9;

  localparam logic [23:0] C_PWR = 24'(PWR_WAIT - 1);
  localparam logic [23:0] C_RLO = 24'(RES_LOW - 1);
  localparam logic [23:0] C_RHI = 24'(RES_WAIT - 1);
  localparam logic [23:0] C_VCC = 24'(VCC_WAIT - 1);

  logic [3:0]         r_state;
  logic [3:0]         w_nxt;
  logic [23:0]        r_cnt;
  logic [2:0]         r_idx;
  logic [1:0]         r_slot;
  logic [WIDTH*N-1:0] r_data;
  logic [N-1:0]       r_dc;
  logic               r_start;
  logic               r_start_d;
  logic               r_ready;
  logic               r_res;
  logic               r_vccen;
  logic               r_pmoden;
  logic               r_init;
  logic               w_fin;
  logic               w_acc;
  logic               w_last;

  function automatic logic [WIDTH*N-1:0] f_rom(input logic [2:0] i_idx);
    case (i_idx)
      3'd0:    f_rom = 64'hA4_00_A2_00_A1_72_A0_AE;
      3'd1:    f_rom = 64'h31_B1_0B_B0_8E_AD_3F_A8;
      3'd2:    f_rom = 64'h64_8C_78_8B_64_8A_F0_B3;
      3'd3:    f_rom = 64'h91_81_06_87_3E_BE_3A_BB;
      3'd4:    f_rom = 64'hE3_E3_E3_E3_7D_83_50_82;
      3'd5:    f_rom = 64'hE3_E3_E3_E3_E3_E3_E3_AF;
      default: f_rom = 64'hE3_E3_E3_E3_E3_E3_E3_E3;
    endcase
  endfunction

  // the buffer's flag may still be up from the previous packet
  // right around a strobe, so it is not trusted there
  assign w_fin  = bus.i_FINAL_BYTE & ~r_start & ~r_start_d;
  assign w_acc  = r_ready & bus.i_PIX_VALID;
  assign w_last = w_acc & (r_slot == 2'd3);

  // next-state decode
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_PWR:      if (r_cnt == C_PWR) w_nxt = S_RES_LO;
      S_RES_LO:   if (r_cnt == C_RLO) w_nxt = S_RES_HI;
      S_RES_HI:   if (r_cnt == C_RHI) w_nxt = S_CMD;
      S_CMD:      w_nxt = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (w_fin) begin
          if (r_idx == 3'd5)      w_nxt = S_READY;
          else if (r_idx == 3'd4) w_nxt = S_VCC;
          else                    w_nxt = S_GAP;
        end
      end
      S_GAP:      w_nxt = r_init ? S_READY : S_CMD;
      S_VCC:      if (r_cnt == C_VCC) w_nxt = S_CMD;
      S_READY:    if (w_last) w_nxt = S_PIX;
      S_PIX:      w_nxt = S_PIX_WAIT;
      S_PIX_WAIT: if (w_fin) w_nxt = S_GAP;
      default:    w_nxt = S_PWR;
    endcase
  end

  // state, delay counter, packet index and pixel slot
  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      r_state <= S_PWR;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 24'd1;
      if (r_state == S_RES_HI)
        r_idx <= '0;
      else if (r_state == S_CMD_WAIT && w_fin && r_idx < 3'd4)
        r_idx <= r_idx + 3'd1;
      else if (r_state == S_VCC)
        r_idx <= 3'd5;
      if (w_acc)
        r_slot <= r_slot + 2'd1;
    end
  end

  // registered pin, strobe and packet outputs
  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      r_data    <= '0;
      r_dc      <= '0;
      r_start   <= 1'b0;
      r_start_d <= 1'b0;
      r_ready   <= 1'b0;
      r_res     <= 1'b1;
      r_vccen   <= 1'b0;
      r_pmoden  <= 1'b0;
      r_init    <= 1'b0;
    end else begin
      r_pmoden  <= 1'b1;
      r_res     <= (r_state != S_RES_LO);
      r_vccen   <= r_vccen | (r_state == S_VCC);
      r_init    <= r_init |
                   (r_state == S_CMD_WAIT && w_fin && r_idx == 3'd5);
      r_ready   <= (w_nxt == S_READY);
      r_start   <= (r_state == S_CMD) | w_last;
      r_start_d <= r_start;
      if (r_state == S_CMD) begin
        r_data <= f_rom(r_idx);
        r_dc   <= '0;
      end else if (w_acc) begin
        r_data[{r_slot, 4'b0000} +: 16] <=
          {bus.i_PIX_DATA[7:0], bus.i_PIX_DATA[15:8]};
        if (w_last)
          r_dc <= '1;
      end
    end
  end

  assign bus.o_DATA      = r_data;
  assign bus.o_DC        = r_dc;
  assign bus.o_START     = r_start;
  assign bus.o_PIX_READY = r_ready;
  assign o_RES           = r_res;
  assign o_VCCEN         = r_vccen;
  assign o_PMODEN        = r_pmoden;
  assign o_INIT_DONE     = r_init;

endmodule

// File: tb/tb_ssd1331_cmd_sequencer.sv
// tb_ssd1331_cmd_sequencer: power-up timing, init packets,
// pixel packing, stray flags and mid-sequence reset.
module tb_ssd1331_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic o_RES, o_VCCEN, o_PMODEN, o_INIT_DONE;
  logic fin_m = 1'b0;
  logic stray = 1'b0;
  logic pv = 1'b0;
  logic [15:0] pd = 16'h0;

  ssd1331_cmd_sequencer_if bus ();
  assign bus.i_FINAL_BYTE = fin_m | stray;
  assign bus.i_PIX_VALID  = pv;
  assign bus.i_PIX_DATA   = pd;

  ssd1331_cmd_sequencer #(
    .WIDTH(8), .N(8), .PWR_WAIT(4), .RES_LOW(3),
    .RES_WAIT(2), .VCC_WAIT(10)
  ) dut (
    .i_SCK(clk),
    .i_RST(rst_n),
    .bus(bus),
    .o_RES(o_RES),
    .o_VCCEN(o_VCCEN),
    .o_PMODEN(o_PMODEN),
    .o_INIT_DONE(o_INIT_DONE)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  dc;
  } pkt_t;

  typedef struct {
    logic [3:0][15:0] pix;
    int               gap;
    logic [63:0]      exp;
  } vec_t;

  pkt_t        exp_q[$];
  int          st_q[$];
  logic [63:0] P [6];
  vec_t        vecs [3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fin_cyc = 0;
  int rst_gen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // buffer model: raises final-byte 64 cycles after each strobe
  initial begin
    int cnt;
    int gen;
    cnt = 0;
    gen = 0;
    forever begin
      @(negedge clk);
      fin_m = 1'b0;
      if (!rst_n || gen != rst_gen) begin
        cnt = 0;
        gen = rst_gen;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          fin_m = 1'b1;
          fin_cyc = cyc;
        end
      end else if (bus.o_START) begin
        cnt = 64;
      end
    end
  end

  // strobe monitor: scoreboard pop and compare
  initial begin
    bit   prev;
    pkt_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_START) begin
        check("start_back_to_back", 64'(prev), 64'd0);
        st_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got data %0h expected none",
                   bus.o_DATA);
        end else begin
          e = exp_q.pop_front();
          check("pkt_data", bus.o_DATA, e.d);
          check("pkt_dc", 64'(bus.o_DC), 64'(e.dc));
        end
      end
      prev = rst_n && bus.o_START;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset(input string tag);
    check({tag, "_pmoden"}, 64'(o_PMODEN), 64'd0);
    check({tag, "_res"}, 64'(o_RES), 64'd1);
    check({tag, "_vccen"}, 64'(o_VCCEN), 64'd0);
    check({tag, "_init"}, 64'(o_INIT_DONE), 64'd0);
    check({tag, "_start"}, 64'(bus.o_START), 64'd0);
    check({tag, "_ready"}, 64'(bus.o_PIX_READY), 64'd0);
    check({tag, "_data"}, bus.o_DATA, 64'd0);
    check({tag, "_dc"}, 64'(bus.o_DC), 64'd0);
  endtask

  // called right after reset release on a falling edge
  task automatic power_up(input bit en_stray);
    int k_pm, k_lo, k_hi, k_st;
    k_pm = 0; k_lo = 0; k_hi = 0; k_st = 0;
    st_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back('{d: P[i], dc: 8'h00});
    check("pmoden_pre", 64'(o_PMODEN), 64'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      stray = en_stray && (k == 2 || k == 6);
      if (o_PMODEN && k_pm == 0) k_pm = k;
      if (!o_RES && k_lo == 0) k_lo = k;
      if (o_RES && k_lo != 0 && k_hi == 0) k_hi = k;
      if (bus.o_START && k_st == 0) k_st = k;
    end
    stray = 1'b0;
    check("pmoden_rise", 64'(k_pm), 64'd1);
    check("res_fall", 64'(k_lo), 64'd5);
    check("res_rise", 64'(k_hi), 64'd8);
    check("first_start", 64'(k_st), 64'd10);
  endtask

  task automatic run_init();
    int v, ic;
    v = -1;
    ic = -1;
    for (int i = 0; i < 2000 && v < 0; i++) begin
      @(negedge clk);
      if (o_VCCEN) v = cyc;
    end
    check("vcc_rise_seen", 64'(v >= 0), 64'd1);
    check("strobes_before_vcc", 64'(st_q.size()), 64'd5);
    for (int i = 1; i < st_q.size() && i < 5; i++)
      check("strobe_spacing", 64'((st_q[i] - st_q[i-1]) >= 66), 64'd1);
    check("init_before_p5", 64'(o_INIT_DONE), 64'd0);
    for (int i = 0; i < 100 && st_q.size() < 6; i++) @(negedge clk);
    check("p5_delay", st_q.size() >= 6 ? 64'(st_q[5] - v) : 64'hFFFF, 64'd10);
    for (int i = 0; i < 200 && ic < 0; i++) begin
      @(negedge clk);
      if (o_INIT_DONE) ic = cyc;
    end
    check("init_rise", 64'(ic), 64'(fin_cyc + 1));
    check("ready_after_init", 64'(bus.o_PIX_READY), 64'd1);
  endtask

  initial begin
    int p, g, n, r;
    P[0] = 64'hA4_00_A2_00_A1_72_A0_AE;
    P[1] = 64'h31_B1_0B_B0_8E_AD_3F_A8;
    P[2] = 64'h64_8C_78_8B_64_8A_F0_B3;
    P[3] = 64'h91_81_06_87_3E_BE_3A_BB;
    P[4] = 64'hE3_E3_E3_E3_7D_83_50_82;
    P[5] = 64'hE3_E3_E3_E3_E3_E3_E3_AF;
    vecs[0] = '{pix: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234},
                gap: 0, exp: 64'hF0DE_BC9A_7856_3412};
    vecs[1] = '{pix: {16'h7E5A, 16'h8001, 16'hFF00, 16'h0001},
                gap: 0, exp: 64'h5A7E_0180_00FF_0100};
    vecs[2] = '{pix: {16'h07E0, 16'hF800, 16'h0000, 16'hFFFF},
                gap: 2, exp: 64'hE007_00F8_0000_FFFF};

    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    power_up(1'b0);
    run_init();

    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ready", 64'(bus.o_PIX_READY), 64'd1);
    check("stray_strobes", 64'(st_q.size()), 64'd6);
    check("stray_data", bus.o_DATA, P[5]);
    check("stray_init", 64'(o_INIT_DONE), 64'd1);

    for (int v = 0; v < 3; v++) begin
      check("pix_ready_idle", 64'(bus.o_PIX_READY), 64'd1);
      exp_q.push_back('{d: vecs[v].exp, dc: 8'hFF});
      p = 0; g = 0; n = 0;
      while (p < 4 && n < 100) begin
        @(negedge clk);
        n++;
        if (g > 0) begin
          pv = 1'b0;
          g--;
        end else begin
          pv = 1'b1;
          pd = vecs[v].pix[p];
          if (bus.o_PIX_READY) begin
            p++;
            g = vecs[v].gap;
          end
        end
      end
      check("pix_accept_cycles", 64'(n), 64'(4 + 3 * vecs[v].gap));
      @(negedge clk);
      pv = 1'b0;
      check("pix_strobe", 64'(bus.o_START), 64'd1);
      check("pix_ready_drop", 64'(bus.o_PIX_READY), 64'd0);
      r = -1;
      for (int i = 0; i < 200 && r < 0; i++) begin
        @(negedge clk);
        if (bus.o_PIX_READY) r = cyc;
      end
      check("pix_ready_return", 64'(r), 64'(fin_cyc + 2));
    end

    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk_reset("rst_ready");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    power_up(1'b1);
    for (int i = 0; i < 1000 && st_q.size() < 3; i++) @(negedge clk);
    check("reach_p2", 64'(st_q.size()), 64'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk_reset("rst_cmdwait");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    power_up(1'b0);
    run_init();
    repeat (100) @(negedge clk);
    check("no_extra_strobes", 64'(st_q.size()), 64'd6);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd1331_cmd_sequencer.md
Name: ssd1331_cmd_sequencer

Overview:
- Upstream stage of the N-byte MOSI buffer. Runs the SSD1331 power-up sequence: PMOD power, RES pulse, and the command packets for register init, VCC enable and display on.
- After init it packs a stream of RGB565 pixels into 8-byte data packets.
- Drives the buffer's packet bus (i_DATA, i_DC, i_START) and paces itself on the buffer's final-byte flag. Clocked in the same SCK domain as the buffer.

Parameters:
WIDTH, 8, bits per byte; only 8 supported
N, 8, bytes per packet; only 8 supported
PWR_WAIT, 128, cycles from o_PMODEN high to RES low
RES_LOW, 32, cycles o_RES held low
RES_WAIT, 32, cycles after RES release before first packet
VCC_WAIT, 625000, cycles after o_VCCEN high before display-on packet (100 ms at 6.25 MHz)

Ports:
i_SCK  in  1  clock, shared with the MOSI buffer
i_RST  in  1  asynchronous, active-low reset
i_FINAL_BYTE  in  1  from buffer o_MOSI_FINAL_BYTE; high = packet done
i_PIX_VALID  in  1  pixel offered
i_PIX_DATA  in  16  RGB565 pixel
o_PIX_READY  out  1  pixel accepted when VALID&READY
o_DATA  out  WIDTH*N  packet to buffer; byte 0 in [7:0], sent first
o_DC  out  N  per-byte D/C flag; 0 = command, 1 = data
o_START  out  1  one-cycle packet launch strobe
o_RES  out  1  OLED RES pin, active low
o_VCCEN  out  1  OLED VCC enable
o_PMODEN  out  1  PMOD power enable
o_INIT_DONE  out  1  high once display-on packet completes

Behaviour:
- Reset (i_RST=0, async): all outputs 0 except o_RES=1; state S_PWR; counters and pixel slot cleared. Reset mid-operation aborts at once; any packet in flight is abandoned.
- Delay state with parameter D lasts exactly D cycles: counter cleared on entry, exit when count==D-1. Counter is 24 bits, so every parameter must be ≥1 and <2^24.
- State sequence:
  - S_PWR: o_PMODEN=1 (held thereafter). After PWR_WAIT, go to S_RES_LO.
  - S_RES_LO: o_RES=0. After RES_LOW, go to S_RES_HI.
  - S_RES_HI: o_RES=1. After RES_WAIT, go to S_CMD with idx=0.
  - S_CMD: drive ROM[idx] on o_DATA, o_DC=8'h00, o_START=1 for this one cycle; go to S_CMD_WAIT.
  - S_CMD_WAIT: hold o_DATA/o_DC. Ignore i_FINAL_BYTE on the first cycle after the strobe.
    - On i_FINAL_BYTE=1 with idx<4: idx++, go to S_GAP, then S_CMD.
    - On i_FINAL_BYTE=1 with idx==4: go to S_VCC.
    - On i_FINAL_BYTE=1 with idx==5: o_INIT_DONE=1, go to S_READY.
  - S_GAP: one idle cycle so the buffer returns to idle before the next strobe.
  - S_VCC: o_VCCEN=1 (held thereafter). After VCC_WAIT, idx=5, go to S_CMD.
- Command ROM, listed byte 0 first:
  - P0: AE A0 72 A1 00 A2 00 A4
  - P1: A8 3F AD 8E B0 0B B1 31
  - P2: B3 F0 8A 64 8B 78 8C 64
  - P3: BB 3A BE 3E 87 06 81 91
  - P4: 82 50 83 7D E3 E3 E3 E3
  - P5: AF E3 E3 E3 E3 E3 E3 E3
  - E3 is the SSD1331 NOP, used as padding.
- S_READY: o_PIX_READY=1.
  - Each VALID&READY handshake stores pixel k (k=0..3) with the high byte in byte 2k and the low byte in byte 2k+1.
  - On the 4th accept, the next cycle is S_PIX: o_PIX_READY=0, o_DC=8'hFF, o_START=1 for one cycle, slot count cleared.
  - S_PIX_WAIT: wait for i_FINAL_BYTE, then S_GAP, then S_READY.
  - VALID low: no accept and no state change. Partial packets (fewer than 4 pixels) stay held indefinitely; there is no flush.
- o_START is never high on two consecutive cycles, and never while a packet is outstanding.
- o_DATA/o_DC change only on the strobe cycle, except pixel bytes filling during S_READY.
- o_INIT_DONE, once high, stays high until reset.
- i_FINAL_BYTE is ignored in every state other than the two wait states.

Test Plan:
- Reset release, PWR_WAIT=4, RES_LOW=3, RES_WAIT=2 -> o_PMODEN rises 1 cycle after release; o_RES low exactly 3 cycles starting cycle 5; first o_START 2 cycles after o_RES rises, with o_DATA=64'hA4_00A2_00A1_72A0_AE and o_DC=00.
- Bench buffer model answers each strobe with i_FINAL_BYTE after 64 cycles -> exactly 5 strobes before o_VCCEN rises; packets match P0..P4; strobes ≥66 cycles apart.
- VCC_WAIT=10 -> P5 strobe (byte0=AF) exactly 10 cycles after o_VCCEN rises; o_INIT_DONE rises on the cycle after its i_FINAL_BYTE.
- After init, pixels 1234, 5678, 9ABC, DEF0 offered back-to-back -> 4 accepts in 4 cycles; o_START with o_DATA=64'hF0DE_BC9A_7856_3412 and o_DC=FF; o_PIX_READY low until one cycle after i_FINAL_BYTE.
- Stray i_FINAL_BYTE pulse in S_READY and during delay states -> no state or output change.
- i_RST low for 1 cycle while in S_CMD_WAIT idx=2 -> outputs at once return to reset values; full sequence restarts from S_PWR.
